// File: rtl/dual_bus_interface_if.sv
// Host-side DUART bus bundle: 68000-style strobes in, decoder controls and DTACKN out.
interface dual_bus_interface_if;
  logic       CSN;
  logic       RWN;
  logic [3:0] RS;
  logic       IACKN;
  logic [2:0] A;
  logic       E_LO;
  logic       E_HI;
  logic       RWQ;
  logic       DATA_OE;
  logic       VEC_OE;
  logic       DTACKN;

  modport slave (
    input  CSN, RWN, RS, IACKN,
    output A, E_LO, E_HI, RWQ, DATA_OE, VEC_OE, DTACKN
  );

  modport master (
    output CSN, RWN, RS, IACKN,
    input  A, E_LO, E_HI, RWQ, DATA_OE, VEC_OE, DTACKN
  );
endinterface

// File: rtl/dual_bus_interface.sv
// DUART host bus sequencer: synchronises CSN, latches RS/RWN, strobes one of two decoders, returns DTACKN.
// Optional interrupt-acknowledge vector cycle is enabled by defining DUART_IACK_EN.
module dual_bus_interface #(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_DELAY   = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  dual_bus_interface_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, LATCH, STROBE, WAIT, ACK, RELEASE} state_t;

  localparam bit        USE_WAIT  = (ACK_DELAY > 1);
  localparam logic [3:0] WAIT_LOAD = (ACK_DELAY > 1) ? 4'(ACK_DELAY - 2) : 4'd0;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [2:0]             a_q, a_d;
  logic                   bank_q, bank_d;
  logic                   rwq_q, rwq_d;
  logic                   armed_q, armed_d;
  logic                   e_lo_q, e_lo_d;
  logic                   e_hi_q, e_hi_d;
  logic                   data_oe_q, data_oe_d;
  logic                   dtackn_q, dtackn_d;
  logic                   cs_s, bus_idle, rel;

  assign cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], bus.CSN};
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];

`ifdef DUART_IACK_EN
  logic [SYNC_STAGES-1:0] iack_sync_q, iack_sync_d;
  logic                   iack_s;
  logic                   vec_q, vec_d;
  logic                   vec_oe_q, vec_oe_d;

  assign iack_sync_d = {iack_sync_q[SYNC_STAGES-2:0], bus.IACKN};
  assign iack_s      = iack_sync_q[SYNC_STAGES-1];
  assign bus_idle    = cs_s & iack_s;
  // A vector cycle is released by IACKN, a register cycle by CSN.
  assign rel         = vec_q ? iack_s : cs_s;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      iack_sync_q <= '1;
      vec_q       <= 1'b0;
      vec_oe_q    <= 1'b0;
    end else begin
      iack_sync_q <= iack_sync_d;
      vec_q       <= vec_d;
      vec_oe_q    <= vec_oe_d;
    end
  end

  assign bus.VEC_OE = vec_oe_q;
`else
  assign bus_idle   = cs_s;
  assign rel        = cs_s;
  assign bus.VEC_OE = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    bank_d    = bank_q;
    rwq_d     = rwq_q;
    armed_d   = armed_q;
    e_lo_d    = 1'b0;
    e_hi_d    = 1'b0;
    data_oe_d = data_oe_q;
    dtackn_d  = dtackn_q;
`ifdef DUART_IACK_EN
    vec_d     = vec_q;
    vec_oe_d  = vec_oe_q;
`endif
    case (state_q)
      IDLE: begin
        // armed_q demands the bus be seen idle first, so only a fresh falling strobe starts a cycle.
        if (armed_q && !cs_s) begin
          state_d = LATCH;
          a_d     = bus.RS[2:0];
          bank_d  = bus.RS[3];
          rwq_d   = bus.RWN;
`ifdef DUART_IACK_EN
          vec_d   = 1'b0;
        end else if (armed_q && !iack_s) begin
          state_d = LATCH;
          vec_d   = 1'b1;
`endif
        end else if (bus_idle) begin
          armed_d = 1'b1;
        end
      end
      LATCH: begin
        if (rel) begin
          state_d = IDLE;
        end else begin
          state_d = STROBE;
`ifdef DUART_IACK_EN
          if (vec_q) vec_oe_d = 1'b1;
          else
`endif
          begin
            e_lo_d    = ~bank_q;
            e_hi_d    = bank_q;
            data_oe_d = rwq_q;
          end
        end
      end
      STROBE, WAIT: begin
        if (rel) begin
          state_d   = IDLE;
          data_oe_d = 1'b0;
`ifdef DUART_IACK_EN
          vec_oe_d  = 1'b0;
`endif
        end else if (state_q == STROBE && USE_WAIT) begin
          state_d = WAIT;
          cnt_d   = WAIT_LOAD;
        end else if (state_q == STROBE || cnt_q == 4'd0) begin
          state_d  = ACK;
          dtackn_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        if (rel) begin
          state_d   = RELEASE;
          dtackn_d  = 1'b1;
          data_oe_d = 1'b0;
          armed_d   = 1'b0;
`ifdef DUART_IACK_EN
          vec_oe_d  = 1'b0;
`endif
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cs_sync_q <= '1;
      cnt_q     <= 4'd0;
      a_q       <= 3'd0;
      bank_q    <= 1'b0;
      rwq_q     <= 1'b1;
      armed_q   <= 1'b1;
      e_lo_q    <= 1'b0;
      e_hi_q    <= 1'b0;
      data_oe_q <= 1'b0;
      dtackn_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cs_sync_q <= cs_sync_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      bank_q    <= bank_d;
      rwq_q     <= rwq_d;
      armed_q   <= armed_d;
      e_lo_q    <= e_lo_d;
      e_hi_q    <= e_hi_d;
      data_oe_q <= data_oe_d;
      dtackn_q  <= dtackn_d;
    end
  end

  assign bus.A       = a_q;
  assign bus.RWQ     = rwq_q;
  assign bus.E_LO    = e_lo_q;
  assign bus.E_HI    = e_hi_q;
  assign bus.DATA_OE = data_oe_q;
  assign bus.DTACKN  = dtackn_q;
endmodule
